// File: rtl/sync_updown_ctr.sv
//----------------------------------------------------------------------------
// sync_updown_ctr
//
// Synchronous modulo-MODULUS up/down counter with parallel load, count
// enable and cascade outputs. The counting direction can change on any
// cycle. Multi-digit counters are built by feeding one stage's tc into the
// next stage's en. Every stage shares clk and clear_n, so there are no
// ripple clocks.
//
// Parameters
//   WIDTH    counter and load width in bits (2..16)
//   MODULUS  count range 0..MODULUS-1 (2..2**WIDTH)
//
// Ports
//   clk      clock; all state changes happen on the rising edge
//   clear_n  synchronous active-low clear (no asynchronous effect)
//   en       count enable
//   up       direction: 1 = increment, 0 = decrement
//   load     parallel load strobe (takes priority over en)
//   din      parallel load value, clamped to MODULUS-1 if out of range
//   q        registered count
//   tc       combinational terminal count; high in the cycle whose edge
//            will wrap, used as the cascade enable
//   wrap     registered one-cycle pulse after a wrap
//   zero     registered flag, equal to (q == 0) after every edge
//----------------------------------------------------------------------------
module sync_updown_ctr #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             zero
);

   // All arithmetic is done one bit wider than the count so that an
   // increment from 2**WIDTH-1 is still visible as a value larger than
   // LAST_EXT. The wrap decision always comes from the compare, never from
   // natural overflow, so MODULUS = 2**WIDTH behaves like any other modulus.
   localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

   logic [WIDTH:0] q_ext;
   logic [WIDTH:0] inc_ext;
   logic [WIDTH:0] dec_ext;
   logic [WIDTH:0] din_ext;
   logic [WIDTH:0] next_ext;
   logic           at_last;
   logic           at_zero;
   logic           wrap_next;

   // Widened copies of the count and load value, plus the two end-of-range
   // compares that drive both the wrap decision and the terminal count.
   assign q_ext   = {1'b0, q};
   assign din_ext = {1'b0, din};
   assign inc_ext = q_ext + ONE_EXT;
   assign dec_ext = q_ext - ONE_EXT;
   assign at_last = (q_ext == LAST_EXT);
   assign at_zero = (q_ext == '0);

   // Terminal count is purely combinational so a downstream stage sees its
   // enable in the same cycle. It has no path from din, and is forced low
   // whenever the coming edge will clear or load instead of count.
   assign tc = clear_n & ~load & en & ((up & at_last) | (~up & at_zero));

   // Next-state selection for the non-clear cases: load (with saturating
   // clamp), then count in the selected direction, then hold. wrap_next is
   // only raised when a count step crosses an end of the range.
   always_comb begin
      next_ext  = q_ext;
      wrap_next = 1'b0;
      if (load) begin
         next_ext = (din_ext > LAST_EXT) ? LAST_EXT : din_ext;
      end else if (en) begin
         if (up) begin
            if (at_last) begin
               next_ext  = '0;
               wrap_next = 1'b1;
            end else begin
               next_ext = inc_ext;
            end
         end else begin
            if (at_zero) begin
               next_ext  = LAST_EXT;
               wrap_next = 1'b1;
            end else begin
               next_ext = dec_ext;
            end
         end
      end
   end

   // State register. Clear wins over everything and also drops any wrap
   // pulse currently showing. zero is registered from the same next value
   // as q so the two can never disagree.
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         q    <= '0;
         wrap <= 1'b0;
         zero <= 1'b1;
      end else begin
         q    <= next_ext[WIDTH-1:0];
         wrap <= wrap_next;
         zero <= (next_ext == '0);
      end
   end

endmodule

// File: tb/tb_sync_updown_ctr.sv
//----------------------------------------------------------------------------
// tb_sync_updown_ctr
//
// Drives four counter stages from one directed-then-random sequence:
//   ones  WIDTH 4, MODULUS 10 (main stage under test)
//   tens  WIDTH 4, MODULUS 10, en fed from ones.tc (cascade)
//   m8    WIDTH 3, MODULUS 8  (modulus equals 2**WIDTH)
//   m2    WIDTH 2, MODULUS 2  (back-to-back wraps)
// Each stage is compared every cycle against a reference model that works
// on plain integers with modular arithmetic.
//----------------------------------------------------------------------------
module tb_sync_updown_ctr;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] din;
   logic [2:0] din8;
   logic [1:0] din2;
   logic       tens_up;
   logic       tens_load;
   logic [3:0] tens_din;

   logic [3:0] ones_q;
   logic       ones_tc;
   logic       ones_wrap;
   logic       ones_zero;
   logic [3:0] tens_q;
   logic       tens_tc;
   logic       tens_wrap;
   logic       tens_zero;
   logic [2:0] m8_q;
   logic       m8_tc;
   logic       m8_wrap;
   logic       m8_zero;
   logic [1:0] m2_q;
   logic       m2_tc;
   logic       m2_wrap;
   logic       m2_zero;

   int test_cnt = 0;
   int fail_cnt = 0;

   // Reference model state: index 0 ones, 1 tens, 2 m8, 3 m2
   int mcnt[4];
   bit mwrap[4];
   int mmod[4] = '{10, 10, 8, 2};

   always #5 clk = ~clk;

   sync_updown_ctr #(.WIDTH(4), .MODULUS(10)) u_ones (
      .clk(clk), .clear_n(clear_n), .en(en), .up(up), .load(load), .din(din),
      .q(ones_q), .tc(ones_tc), .wrap(ones_wrap), .zero(ones_zero)
   );

   sync_updown_ctr #(.WIDTH(4), .MODULUS(10)) u_tens (
      .clk(clk), .clear_n(clear_n), .en(ones_tc), .up(tens_up), .load(tens_load),
      .din(tens_din), .q(tens_q), .tc(tens_tc), .wrap(tens_wrap), .zero(tens_zero)
   );

   sync_updown_ctr #(.WIDTH(3), .MODULUS(8)) u_m8 (
      .clk(clk), .clear_n(clear_n), .en(en), .up(up), .load(load), .din(din8),
      .q(m8_q), .tc(m8_tc), .wrap(m8_wrap), .zero(m8_zero)
   );

   sync_updown_ctr #(.WIDTH(2), .MODULUS(2)) u_m2 (
      .clk(clk), .clear_n(clear_n), .en(en), .up(up), .load(load), .din(din2),
      .q(m2_q), .tc(m2_tc), .wrap(m2_wrap), .zero(m2_zero)
   );

   // Terminal count predicted from the model: the coming edge will wrap.
   function automatic bit model_tc(int idx, bit c, bit e, bit u, bit l);
      int raw;
      raw = mcnt[idx] + (u ? 1 : -1);
      return c && !l && e && (raw < 0 || raw >= mmod[idx]);
   endfunction

   // One edge of the model, written as modular arithmetic on integers.
   function automatic void model_step(int idx, bit c, bit e, bit u, bit l, int d);
      int raw;
      if (!c) begin
         mcnt[idx]  = 0;
         mwrap[idx] = 1'b0;
      end else if (l) begin
         mcnt[idx]  = (d > mmod[idx] - 1) ? mmod[idx] - 1 : d;
         mwrap[idx] = 1'b0;
      end else if (e) begin
         raw        = mcnt[idx] + (u ? 1 : -1);
         mwrap[idx] = (raw < 0 || raw >= mmod[idx]);
         mcnt[idx]  = (raw + mmod[idx]) % mmod[idx];
      end else begin
         mwrap[idx] = 1'b0;
      end
   endfunction

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkInst(string name, int idx, logic [31:0] q_obs,
                            logic [31:0] wrap_obs, logic [31:0] zero_obs);
      checkOutput({name, "_q"}, q_obs, 32'(mcnt[idx]));
      checkOutput({name, "_wrap"}, wrap_obs, 32'(mwrap[idx]));
      checkOutput({name, "_zero"}, zero_obs, 32'(mcnt[idx] == 0));
   endtask

   // Check tc before the edge, advance one clock, then check registered
   // outputs one time unit after the edge.
   task automatic stepCycle();
      bit t[4];
      int dins[4];
      #1;
      t[0] = model_tc(0, clear_n, en, up, load);
      t[1] = model_tc(1, clear_n, t[0], tens_up, tens_load);
      t[2] = model_tc(2, clear_n, en, up, load);
      t[3] = model_tc(3, clear_n, en, up, load);
      checkOutput("ones_tc", 32'(ones_tc), 32'(t[0]));
      checkOutput("tens_tc", 32'(tens_tc), 32'(t[1]));
      checkOutput("m8_tc",   32'(m8_tc),   32'(t[2]));
      checkOutput("m2_tc",   32'(m2_tc),   32'(t[3]));
      dins[0] = int'(din);
      dins[1] = int'(tens_din);
      dins[2] = int'(din8);
      dins[3] = int'(din2);
      @(posedge clk);
      model_step(0, clear_n, en, up, load, dins[0]);
      model_step(1, clear_n, t[0], tens_up, tens_load, dins[1]);
      model_step(2, clear_n, en, up, load, dins[2]);
      model_step(3, clear_n, en, up, load, dins[3]);
      #1;
      checkInst("ones", 0, 32'(ones_q), 32'(ones_wrap), 32'(ones_zero));
      checkInst("tens", 1, 32'(tens_q), 32'(tens_wrap), 32'(tens_zero));
      checkInst("m8",   2, 32'(m8_q),   32'(m8_wrap),   32'(m8_zero));
      checkInst("m2",   3, 32'(m2_q),   32'(m2_wrap),   32'(m2_zero));
   endtask

   task automatic applyStimulus(bit c, bit e, bit u, bit l, int d);
      clear_n = c;
      en      = e;
      up      = u;
      load    = l;
      din     = 4'(d);
      din8    = 3'($urandom_range(0, 7));
      din2    = 2'($urandom_range(0, 3));
      stepCycle();
   endtask

   initial begin
      int down_exp[4];
      clear_n   = 1'b0;
      en        = 1'b0;
      up        = 1'b1;
      load      = 1'b0;
      din       = '0;
      din8      = '0;
      din2      = '0;
      tens_up   = 1'b1;
      tens_load = 1'b0;
      tens_din  = '0;
      foreach (mcnt[i]) begin
         mcnt[i]  = 0;
         mwrap[i] = 1'b0;
      end

      // Reset with en and load active; clear must win
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 7);
      checkOutput("reset_q",    32'(ones_q),    32'd0);
      checkOutput("reset_zero", 32'(ones_zero), 32'd1);
      checkOutput("reset_wrap", 32'(ones_wrap), 32'd0);
      checkOutput("reset_tc",   32'(ones_tc),   32'd0);

      // Release with no enable: q stays 0
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      checkOutput("release_q", 32'(ones_q), 32'd0);

      // Up-count through the wrap
      for (int i = 1; i <= 11; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
         checkOutput("up_q",    32'(ones_q),    32'(i % 10));
         checkOutput("up_wrap", 32'(ones_wrap), 32'(i == 10));
      end

      // Load 2, count down through the wrap, then flip direction
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2);
      checkOutput("down_load_q", 32'(ones_q), 32'd2);
      down_exp = '{1, 0, 9, 0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, (i == 3), 1'b0, 0);
         checkOutput("down_q", 32'(ones_q), 32'(down_exp[i]));
      end

      // Load priority over a pending wrap, then the clamp
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4);
      checkOutput("load_q",    32'(ones_q),    32'd4);
      checkOutput("load_wrap", 32'(ones_wrap), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 13);
      checkOutput("clamp_q", 32'(ones_q), 32'd9);

      // Hold at 6
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 6);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'(i % 2), 1'b0, 0);
         checkOutput("hold_q",    32'(ones_q),    32'd6);
         checkOutput("hold_wrap", 32'(ones_wrap), 32'd0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 19) != 0),
                       ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 15)));
      end

      // Two-digit cascade from 00 to 99, then clear at the wrapping edge
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0);
      for (int i = 1; i <= 99; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 0);
         checkOutput("cascade_value", 32'(ones_q) + 32'(tens_q) * 32'd10, 32'(i));
      end
      #1;
      checkOutput("cascade_ones_tc", 32'(ones_tc), 32'd1);
      checkOutput("cascade_tens_tc", 32'(tens_tc), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
      checkOutput("cascade_clr_ones", 32'(ones_q), 32'd0);
      checkOutput("cascade_clr_tens", 32'(tens_q), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0);
      checkOutput("cascade_no_wrap_ones", 32'(ones_wrap), 32'd0);
      checkOutput("cascade_no_wrap_tens", 32'(tens_wrap), 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/sync_updown_ctr.md
# sync_updown_ctr

Synchronous modulo-N up/down counter with parallel load, count enable and cascade outputs, built on the team's D flip-flop register cells in the synchronous-counter tree. Its counting direction is selectable per cycle, so the same block serves as an incrementing or decrementing stage. Multi-digit counters are built by chaining the `tc` output of one stage into the `en` input of the next.

## Interface
- `WIDTH`, 4, counter and load width in bits; legal range 2–16.
- `MODULUS`, 10, count range 0..MODULUS-1; legal range 2 to 2^WIDTH.
- `clk`  input  1  clock; all state changes on the rising edge.
- `clear_n`  input  1  synchronous reset, active-low. Sampled on the rising edge of `clk` only; it has no asynchronous effect.
- `en`  input  1  count enable.
- `up`  input  1  direction; 1 = increment, 0 = decrement.
- `load`  input  1  parallel load strobe.
- `din`  input  WIDTH  parallel load value.
- `q`  output  WIDTH  registered count.
- `tc`  output  1  combinational terminal count, used as the cascade enable.
- `wrap`  output  1  registered one-cycle pulse after a wrap.
- `zero`  output  1  registered flag, 1 when `q == 0`.

## Operation
- Priority at each rising edge: `clear_n` low, then `load`, then `en`, then hold.
- `clear_n` low: `q` = 0, `wrap` = 0, `zero` = 1, regardless of `load`, `en` and `up`.
- `load` high:
  - If `din` ≤ MODULUS-1, `q` takes `din`.
  - If `din` ≥ MODULUS, `q` takes MODULUS-1 (saturating clamp, never out of range).
  - `wrap` = 0 on that cycle.
  - `en` is ignored.
- `en` high, `up` = 1: `q` = `q`+1, except `q` = MODULUS-1 goes to 0 and sets `wrap` for the next cycle.
- `en` high, `up` = 0: `q` = `q`-1, except `q` = 0 goes to MODULUS-1 and sets `wrap` for the next cycle.
- `en` low: `q` holds; `wrap` = 0.
- Arithmetic:
  - Increment and decrement are computed at WIDTH+1 bits, then compared against MODULUS-1 and 0.
  - When MODULUS = 2^WIDTH, the wrap comes from the compare, not from natural overflow; both must give identical results.
- `tc` = `clear_n` & ~`load` & `en` & ((`up` & `q` == MODULUS-1) | (~`up` & `q` == 0)).
  - `tc` is high exactly in the cycle whose edge will wrap.
- `zero` is registered alongside `q` and always equals (`q` == 0) after every edge.
- Direction change mid-count takes effect at the next edge with no extra state: from `q` = 0, `up` = 0 wraps to MODULUS-1.
- Out-of-range state (reachable only via X at power-up before reset) is not supported. Bench must assert `clear_n` before checking.

## Timing
- Latency: one clock from `en`, `load` or `clear_n` to `q`, `wrap` and `zero`.
- `tc` has zero latency. It is combinational from `q`, `en`, `up`, `load` and `clear_n`, with no path from `din`.
- Reset values: `q` = 0, `wrap` = 0, `zero` = 1; `tc` = 0 while `clear_n` is low.
- Reset asserted mid-count: the next edge clears the counter. A `wrap` pulse already showing is dropped at that edge.
- `wrap` is high for exactly one cycle per wrap. Back-to-back wraps (MODULUS = 2, `en` held) give `wrap` high on consecutive cycles.
- Cascade rule: stage k+1 `en` = stage k `tc`. Every stage shares `clk` and `clear_n`; no ripple clocks.

## Test plan
- Reset and power-up:
  - Stimulus: `clear_n` = 0 for 2 edges with `en` = 1 and `load` = 1, `din` = 7.
  - Required: `q` = 0, `zero` = 1, `wrap` = 0, `tc` = 0.
  - Then release `clear_n`: `q` stays 0 until the first enabled edge.
- Up-count wrap (MODULUS = 10):
  - Stimulus: `en` = 1, `up` = 1 from 0 for 11 edges.
  - Required: `q` runs 1..9, then 0, then 1.
  - `tc` is high only while `q` = 9; `wrap` is high only in the cycle after `q` returns to 0.
- Down-count wrap and direction flip:
  - Stimulus: load 2, then `up` = 0 for 3 edges, then `up` = 1 for 1 edge.
  - Required: `q` = 2, 1, 0, 9, then 0.
  - `tc` is high while `q` = 0 with `up` = 0; `wrap` pulses once.
- Load priority and clamp:
  - Stimulus: with `en` = 1, `load` = 1, `din` = 4 at `q` = 9 with `up` = 1.
  - Required: `q` = 4, `tc` = 0, no `wrap`.
  - Then `din` = 13: `q` = 9.
- Hold:
  - Stimulus: `en` = 0 for 5 edges at `q` = 6.
  - Required: `q` = 6 throughout, `tc` = 0, `wrap` = 0.
- Reset mid-operation and cascade:
  - Stimulus: two stages (tens, ones) counting up from 00 to 99, then `clear_n` = 0 at the edge where `tc` = 1.
  - Required: tens increments only on ones wrap.
  - At the reset edge, both stages go to 0 and no `wrap` pulse follows.
